imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, output width; legal values 32 and 64 only.
REQ-002 Parameter AUTO_DECODE, default 0; 0 = format from sel, 1 = format from instr[6:0] and sel ignored.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  instr/sel valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 instr  input  32  full RV instruction word.
REQ-008 sel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
REQ-009 out_valid  output  1  imm_ext/fmt/illegal valid.
REQ-010 out_ready  input  1  consumer accepts output this cycle.
REQ-011 imm_ext  output  XLEN  sign-extended immediate.
REQ-012 fmt  output  3  format applied, same encoding as sel; 111 when illegal.
REQ-013 illegal  output  1  unmapped sel/opcode for this result.
REQ-014 err_count  output  8  saturating count of accepted illegal inputs.

Function
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational; single output register, full throughput).
REQ-017 Latency SHALL be exactly 1 cycle: result of an input accepted at edge N is presented with out_valid=1 after edge N.
REQ-018 While out_valid && !out_ready, imm_ext, fmt and illegal SHALL hold stable.
REQ-019 Output transfer and input transfer in the same cycle: out_valid stays 1 and the register loads the new result; no bubble.
REQ-020 Output transfer with no input transfer: out_valid clears at that edge.
REQ-021 I: imm = sext(instr[31:20]).
REQ-022 S: imm = sext({instr[31:25], instr[11:7]}).
REQ-023 B: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-024 U: imm = sext({instr[31:12], 12'b0}); bits above 31 replicate instr[31] when XLEN=64.
REQ-025 J: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-026 Sign extension SHALL always use instr[31], to full XLEN.
REQ-027 AUTO_DECODE=1 map: 0000011, 0010011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0011011 -> I only when XLEN=64; all others illegal.
REQ-028 Illegal result: imm_ext = 0, fmt = 111, illegal = 1.
REQ-029 err_count SHALL increment by 1 per accepted illegal input and saturate at 255; no wrap.
REQ-030 in_valid=0 SHALL leave register contents and err_count unchanged.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force out_valid=0, imm_ext=0, fmt=000, illegal=0, err_count=0.
REQ-032 During reset, in_ready SHALL read 1 (out_valid=0); no input is captured while rst_n is low.
REQ-033 Reset asserted with out_valid=1 and out_ready=0 SHALL discard the pending result; the first result after reset deasserts comes from the first post-reset accepted input.

Verification
REQ-034 Format coverage, XLEN=32, AUTO_DECODE=0, out_ready=1; each result 1 cycle later:
- sel=000, instr=FFC4A303 -> imm_ext=FFFFFFFC, fmt=000.
- sel=001, instr=0064A423 -> 00000008.
- sel=010, instr=FE420AE3 -> FFFFFFF4.
- sel=011, instr=12345037 -> 12345000.
- sel=100, instr=008000EF -> 00000008.
REQ-035 Back-to-back inputs on consecutive cycles with out_ready=1 -> one result per cycle, out_valid continuously 1, in_ready continuously 1.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable over those cycles. Raise out_ready -> held result transfers and the next input is accepted in the same cycle.
REQ-037 Illegal handling: sel=101, and separately AUTO_DECODE=1 with instr=00000033 -> imm_ext=0, fmt=111, illegal=1, err_count increments. 300 consecutive illegal inputs -> err_count=255.
REQ-038 XLEN=64, AUTO_DECODE=1, instr=800000B7 -> imm_ext=FFFFFFFF80000000, fmt=011.
REQ-039 Reset mid-operation: assert rst_n=0 while out_valid=1, out_ready=0 -> out_valid=0 and err_count=0 before the next clock edge; after release, the next input produces a normal 1-cycle result.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction stream in, immediate stream out.
// The slave modport is the pipeline's view; the master modport drives it.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_ext;
  logic [2:0]      fmt;
  logic            illegal;
  logic [7:0]      err_count;

  modport master (
    output in_valid, instr, sel, out_ready,
    input  in_ready, out_valid, imm_ext, fmt, illegal, err_count
  );

  modport slave (
    input  in_valid, instr, sel, out_ready,
    output in_ready, out_valid, imm_ext, fmt, illegal, err_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// One-stage valid/ready pipeline that extracts and sign-extends RISC-V immediates.
// The format comes from sel, or from the opcode when AUTO_DECODE is set.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_U   = 3'b011,
    FMT_J   = 3'b100,
    FMT_ILL = 3'b111
  } fmt_e;

  fmt_e            dec_fmt;
  logic            dec_ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_full;

  logic            out_valid_q;
  logic [XLEN-1:0] imm_q;
  fmt_e            fmt_q;
  logic            ill_q;
  logic [7:0]      err_q;

  logic            accept;
  logic            in_ready_int;

  // Single output register: we can take a new word whenever the slot is empty
  // or is being drained this same cycle.
  assign in_ready_int = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && in_ready_int;

  always_comb begin
    dec_fmt = FMT_ILL;
    if (AUTO_DECODE) begin
      case (bus.instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
        7'b0100011:                         dec_fmt = FMT_S;
        7'b1100011:                         dec_fmt = FMT_B;
        7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
        7'b1101111:                         dec_fmt = FMT_J;
        // OP-IMM-32 only exists on RV64
        7'b0011011:                         dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
        default:                            dec_fmt = FMT_ILL;
      endcase
    end else begin
      case (bus.sel)
        3'b000:  dec_fmt = FMT_I;
        3'b001:  dec_fmt = FMT_S;
        3'b010:  dec_fmt = FMT_B;
        3'b011:  dec_fmt = FMT_U;
        3'b100:  dec_fmt = FMT_J;
        default: dec_fmt = FMT_ILL;
      endcase
    end
  end

  assign dec_ill = (dec_fmt == FMT_ILL);

  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I:   imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
      FMT_S:   imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      FMT_B:   imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                        bus.instr[30:25], bus.instr[11:8], 1'b0};
      FMT_U:   imm32 = {bus.instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                        bus.instr[20], bus.instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Every format's sign bit is instr[31], so widening to XLEN just replicates it.
    imm_full        = {XLEN{bus.instr[31]}};
    imm_full[31:0]  = imm32;
    if (dec_ill) begin
      imm_full = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      fmt_q       <= FMT_I;
      ill_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      imm_q       <= imm_full;
      fmt_q       <= dec_fmt;
      ill_q       <= dec_ill;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (accept && dec_ill && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.imm_ext   = imm_q;
  assign bus.fmt       = fmt_q;
  assign bus.illegal   = ill_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one sel-driven RV32 instance and two opcode-decoding
// instances (RV64 and RV32) sharing clock and reset.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;

  int pass_count  = 0;
  int check_count = 0;

  imm_gen_pipe_if #(.XLEN(32)) bus32  ();
  imm_gen_pipe_if #(.XLEN(64)) bus64  ();
  imm_gen_pipe_if #(.XLEN(32)) bus32a ();

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64.slave)
  );

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut32a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32a.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives the sel-mode instance, then returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] s, input logic rdy);
    bus32.in_valid  = v;
    bus32.instr     = ins;
    bus32.sel       = s;
    bus32.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic applyAuto(input logic [31:0] ins, input logic [2:0] s);
    bus64.in_valid   = 1'b1;
    bus64.instr      = ins;
    bus64.sel        = s;
    bus64.out_ready  = 1'b1;
    bus32a.in_valid  = 1'b1;
    bus32a.instr     = ins;
    bus32a.sel       = s;
    bus32a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus64.in_valid  = 1'b0;
    bus32a.in_valid = 1'b0;
  endtask

  task automatic checkResult32(input string tag, input logic [31:0] imm, input logic [2:0] f, input logic ill);
    checkOutput({tag, "_valid"}, {63'd0, bus32.out_valid}, 64'd1);
    checkOutput({tag, "_imm"},   {32'd0, bus32.imm_ext},   {32'd0, imm});
    checkOutput({tag, "_fmt"},   {61'd0, bus32.fmt},       {61'd0, f});
    checkOutput({tag, "_ill"},   {63'd0, bus32.illegal},   {63'd0, ill});
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] instr;
    logic [31:0] imm;
  } vec_t;

  vec_t fmt_vecs[5] = '{
    '{3'b000, 32'hFFC4A303, 32'hFFFFFFFC},
    '{3'b001, 32'h0064A423, 32'h00000008},
    '{3'b010, 32'hFE420AE3, 32'hFFFFFFF4},
    '{3'b011, 32'h12345037, 32'h12345000},
    '{3'b100, 32'h008000EF, 32'h00000008}
  };

  initial begin
    rst_n           = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.instr     = '0;
    bus32.sel       = '0;
    bus32.out_ready = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.instr     = '0;
    bus64.sel       = '0;
    bus64.out_ready = 1'b1;
    bus32a.in_valid = 1'b0;
    bus32a.instr    = '0;
    bus32a.sel      = '0;
    bus32a.out_ready = 1'b1;

    // Reset values, and nothing captured while reset is held across an edge.
    #2;
    checkOutput("rst_valid",    {63'd0, bus32.out_valid}, 64'd0);
    checkOutput("rst_imm",      {32'd0, bus32.imm_ext},   64'd0);
    checkOutput("rst_fmt",      {61'd0, bus32.fmt},       64'd0);
    checkOutput("rst_ill",      {63'd0, bus32.illegal},   64'd0);
    checkOutput("rst_err",      {56'd0, bus32.err_count}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, bus32.in_ready},  64'd1);
    applyStimulus(1'b1, 32'hFFC4A303, 3'b000, 1'b1);
    checkOutput("rst_no_capture", {63'd0, bus32.out_valid}, 64'd0);
    rst_n = 1'b1;

    // All five formats back to back; in_ready must stay high throughout.
    foreach (fmt_vecs[i]) begin
      bus32.in_valid  = 1'b1;
      bus32.instr     = fmt_vecs[i].instr;
      bus32.sel       = fmt_vecs[i].sel;
      bus32.out_ready = 1'b1;
      #1;
      checkOutput($sformatf("b2b_in_ready%0d", i), {63'd0, bus32.in_ready}, 64'd1);
      applyStimulus(1'b1, fmt_vecs[i].instr, fmt_vecs[i].sel, 1'b1);
      checkResult32($sformatf("fmt%0d", i), fmt_vecs[i].imm, fmt_vecs[i].sel, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
    checkOutput("drain_valid", {63'd0, bus32.out_valid}, 64'd0);

    // Backpressure: hold result A for three cycles while B waits.
    applyStimulus(1'b1, 32'h00100093, 3'b000, 1'b1);
    checkResult32("bp_a", 32'h00000001, 3'b000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      bus32.in_valid  = 1'b1;
      bus32.instr     = 32'hABCDE037;
      bus32.sel       = 3'b011;
      bus32.out_ready = 1'b0;
      #1;
      checkOutput($sformatf("bp_in_ready%0d", c), {63'd0, bus32.in_ready}, 64'd0);
      applyStimulus(1'b1, 32'hABCDE037, 3'b011, 1'b0);
      checkResult32($sformatf("bp_hold%0d", c), 32'h00000001, 3'b000, 1'b0);
    end
    bus32.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {63'd0, bus32.in_ready}, 64'd1);
    applyStimulus(1'b1, 32'hABCDE037, 3'b011, 1'b1);
    checkResult32("bp_b", 32'hABCDE000, 3'b011, 1'b0);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
    checkOutput("bp_drain_valid", {63'd0, bus32.out_valid}, 64'd0);
    checkOutput("legal_err",      {56'd0, bus32.err_count}, 64'd0);

    // Illegal sel values and err_count saturation.
    applyStimulus(1'b1, 32'hFFFFFFFF, 3'b101, 1'b1);
    checkResult32("ill_sel", 32'h0, 3'b111, 1'b1);
    checkOutput("ill_err1", {56'd0, bus32.err_count}, 64'd1);
    applyStimulus(1'b0, 32'hFFFFFFFF, 3'b110, 1'b1);
    checkOutput("idle_err", {56'd0, bus32.err_count}, 64'd1);
    for (int n = 0; n < 253; n++) begin
      applyStimulus(1'b1, 32'h80000000, 3'b111, 1'b1);
    end
    checkOutput("err_254", {56'd0, bus32.err_count}, 64'd254);
    for (int n = 0; n < 47; n++) begin
      applyStimulus(1'b1, 32'h12345678, 3'b110, 1'b1);
    end
    checkOutput("err_sat", {56'd0, bus32.err_count}, 64'd255);
    checkResult32("ill_last", 32'h0, 3'b111, 1'b1);
    bus32.in_valid = 1'b0;

    // Opcode-decoding instances; sel is deliberately junk and must be ignored.
    applyAuto(32'h800000B7, 3'b101);
    checkOutput("a64_lui_imm",  bus64.imm_ext,           64'hFFFFFFFF80000000);
    checkOutput("a64_lui_fmt",  {61'd0, bus64.fmt},      64'd3);
    checkOutput("a32_lui_imm",  {32'd0, bus32a.imm_ext}, 64'h0000000080000000);
    applyAuto(32'h00000033, 3'b000);
    checkOutput("a64_op_imm",   bus64.imm_ext,            64'd0);
    checkOutput("a64_op_fmt",   {61'd0, bus64.fmt},       64'd7);
    checkOutput("a64_op_ill",   {63'd0, bus64.illegal},   64'd1);
    checkOutput("a64_op_err",   {56'd0, bus64.err_count}, 64'd1);
    applyAuto(32'hFFF0809B, 3'b011);
    checkOutput("a64_addiw_imm", bus64.imm_ext,             64'hFFFFFFFFFFFFFFFF);
    checkOutput("a64_addiw_fmt", {61'd0, bus64.fmt},        64'd0);
    checkOutput("a64_addiw_err", {56'd0, bus64.err_count},  64'd1);
    checkOutput("a32_addiw_ill", {63'd0, bus32a.illegal},   64'd1);
    checkOutput("a32_addiw_fmt", {61'd0, bus32a.fmt},       64'd7);
    checkOutput("a32_addiw_err", {56'd0, bus32a.err_count}, 64'd2);
    applyAuto(32'h0064A423, 3'b111);
    checkOutput("a64_sw_imm",   bus64.imm_ext,       64'd8);
    checkOutput("a64_sw_fmt",   {61'd0, bus64.fmt},  64'd1);
    applyAuto(32'hFE420AE3, 3'b000);
    checkOutput("a64_beq_imm",  bus64.imm_ext,       64'hFFFFFFFFFFFFFFF4);
    checkOutput("a64_beq_fmt",  {61'd0, bus64.fmt},  64'd2);
    applyAuto(32'h008000EF, 3'b000);
    checkOutput("a64_jal_imm",  bus64.imm_ext,       64'd8);
    checkOutput("a64_jal_fmt",  {61'd0, bus64.fmt},  64'd4);
    applyAuto(32'hFFC4A303, 3'b100);
    checkOutput("a64_lw_imm",   bus64.imm_ext,       64'hFFFFFFFFFFFFFFFC);
    checkOutput("a64_lw_fmt",   {61'd0, bus64.fmt},  64'd0);
    checkOutput("a64_lw_ill",   {63'd0, bus64.illegal}, 64'd0);

    // Reset while a result is stalled; the stale result must never reappear.
    applyStimulus(1'b1, 32'h12345037, 3'b011, 1'b1);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b0;
    checkOutput("pre_rst_valid", {63'd0, bus32.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid",    {63'd0, bus32.out_valid}, 64'd0);
    checkOutput("mid_rst_err",      {56'd0, bus32.err_count}, 64'd0);
    checkOutput("mid_rst_imm",      {32'd0, bus32.imm_ext},   64'd0);
    checkOutput("mid_rst_in_ready", {63'd0, bus32.in_ready},  64'd1);
    checkOutput("mid_rst_err_a32",  {56'd0, bus32a.err_count}, 64'd0);
    applyStimulus(1'b1, 32'h008000EF, 3'b100, 1'b0);
    checkOutput("mid_rst_no_capture", {63'd0, bus32.out_valid}, 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0064A423, 3'b001, 1'b1);
    checkResult32("post_rst", 32'h00000008, 3'b001, 1'b0);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
    checkOutput("post_rst_drain", {63'd0, bus32.out_valid}, 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
